// File: rtl/sample_timer_if.sv
// Control/status bundle between the sample timer and its controller.
// The master side drives the strobes and run configuration; the timer is the slave.
interface sample_timer_if #(
  parameter int CNT_W  = 17,
  parameter int WRAP_W = 8
);
  logic              enable_i;
  logic              sample_i;
  logic              start_i;
  logic              stop_i;
  logic              mode_i;
  logic [CNT_W-1:0]  limit_i;
  logic [CNT_W-1:0]  count_o;
  logic              busy_o;
  logic              done_o;
  logic              wrap_o;
  logic [WRAP_W-1:0] wraps_o;

  modport master (
    output enable_i, sample_i, start_i, stop_i, mode_i, limit_i,
    input  count_o, busy_o, done_o, wrap_o, wraps_o
  );

  modport slave (
    input  enable_i, sample_i, start_i, stop_i, mode_i, limit_i,
    output count_o, busy_o, done_o, wrap_o, wraps_o
  );
endinterface

// File: rtl/sample_timer.sv
// Recording-duration timer: counts qualified deserializer sample strobes up to a
// programmable limit, in one-shot (DONE) or continuous (wrap pulse) mode.
module sample_timer #(
  parameter int CNT_W         = 17,
  parameter int DEFAULT_LIMIT = 125000,
  parameter int WRAP_W        = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  sample_timer_if.slave  bus
);

  if (DEFAULT_LIMIT < 1 || DEFAULT_LIMIT > (2**CNT_W) - 1) begin : g_bad_default
    $error("DEFAULT_LIMIT must be nonzero and fit in CNT_W bits");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  limit_q, limit_d;
  logic              mode_q,  mode_d;
  logic              done_q,  done_d;
  logic              wrap_q,  wrap_d;
  logic [WRAP_W-1:0] wraps_q, wraps_d;

  logic              qual;
  logic              terminal;

  // limit_q is never zero once a run is armed, so limit_q-1 is the last count value.
  assign qual     = (state_q == S_RUN) && bus.sample_i && bus.enable_i;
  assign terminal = (count_q == (limit_q - CNT_W'(1)));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
    mode_d  = mode_q;
    done_d  = done_q;
    wrap_d  = 1'b0;
    wraps_d = wraps_q;

    if (bus.stop_i) begin
      state_d = S_IDLE;
      count_d = '0;
      wraps_d = '0;
      done_d  = 1'b0;
    end else if (bus.start_i) begin
      // A sample arriving with start is dropped: the new run begins at zero.
      state_d = S_RUN;
      limit_d = (bus.limit_i == '0) ? CNT_W'(DEFAULT_LIMIT) : bus.limit_i;
      mode_d  = bus.mode_i;
      count_d = '0;
      wraps_d = '0;
      done_d  = 1'b0;
    end else if (qual) begin
      if (terminal) begin
        count_d = '0;
        if (mode_q) begin
          wrap_d = 1'b1;
          if (wraps_q != '1) wraps_d = wraps_q + WRAP_W'(1);
        end else begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      limit_q <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      wraps_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
      wraps_q <= wraps_d;
    end
  end

  assign bus.count_o = count_q;
  assign bus.busy_o  = (state_q == S_RUN);
  assign bus.done_o  = done_q;
  assign bus.wrap_o  = wrap_q;
  assign bus.wraps_o = wraps_q;

endmodule

// File: tb/tb_sample_timer.sv
// Bench for sample_timer: vector table, directed corner sequences and random traffic,
// with two instances (default build and a small-default / 2-bit-wrap build) checked against a sample-count model.
module tb_sample_timer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sample_timer_if #(.CNT_W(17), .WRAP_W(8)) bus ();
  sample_timer_if #(.CNT_W(17), .WRAP_W(2)) bus2 ();

  assign bus2.enable_i = bus.enable_i;
  assign bus2.sample_i = bus.sample_i;
  assign bus2.start_i  = bus.start_i;
  assign bus2.stop_i   = bus.stop_i;
  assign bus2.mode_i   = bus.mode_i;
  assign bus2.limit_i  = bus.limit_i;

  sample_timer #(.CNT_W(17), .DEFAULT_LIMIT(125000), .WRAP_W(8)) u_dut (
    .clk(clk), .reset_n(rst_n), .bus(bus)
  );
  sample_timer #(.CNT_W(17), .DEFAULT_LIMIT(200), .WRAP_W(2)) u_dut2 (
    .clk(clk), .reset_n(rst_n), .bus(bus2)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: a run is described by the number of qualified samples seen
  // since start; every output is derived from that total with plain arithmetic.
  int dflt[2] = '{125000, 200};
  int wmax[2] = '{255, 3};
  bit m_act[2];
  int m_n[2];
  int m_lim[2];
  bit m_mode[2];
  bit m_wrap[2];

  function automatic bit m_fin(int k);
    return m_act[k] && !m_mode[k] && (m_n[k] >= m_lim[k]);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_act[k] = 0; m_n[k] = 0; m_lim[k] = 1; m_mode[k] = 0; m_wrap[k] = 0;
      end else begin
        m_wrap[k] = 0;
        if (bus.stop_i) begin
          m_act[k] = 0; m_n[k] = 0;
        end else if (bus.start_i) begin
          m_act[k]  = 1;
          m_n[k]    = 0;
          m_lim[k]  = (bus.limit_i == 0) ? dflt[k] : int'(bus.limit_i);
          m_mode[k] = bus.mode_i;
        end else if (m_act[k] && !m_fin(k) && bus.sample_i && bus.enable_i) begin
          m_n[k]++;
          if (m_mode[k] && (m_n[k] % m_lim[k] == 0)) m_wrap[k] = 1;
        end
      end
    end
  end

  function automatic int e_cnt(int k);
    return m_act[k] ? (m_n[k] % m_lim[k]) : 0;
  endfunction
  function automatic int e_wraps(int k);
    int w;
    w = (m_act[k] && m_mode[k]) ? (m_n[k] / m_lim[k]) : 0;
    return (w > wmax[k]) ? wmax[k] : w;
  endfunction

  task automatic check_model();
    chk("m0_count", bus.count_o,  e_cnt(0));
    chk("m0_busy",  bus.busy_o,   m_act[0] && !m_fin(0));
    chk("m0_done",  bus.done_o,   m_fin(0));
    chk("m0_wrap",  bus.wrap_o,   m_wrap[0]);
    chk("m0_wraps", bus.wraps_o,  e_wraps(0));
    chk("m1_count", bus2.count_o, e_cnt(1));
    chk("m1_busy",  bus2.busy_o,  m_act[1] && !m_fin(1));
    chk("m1_done",  bus2.done_o,  m_fin(1));
    chk("m1_wrap",  bus2.wrap_o,  m_wrap[1]);
    chk("m1_wraps", bus2.wraps_o, e_wraps(1));
  endtask

  task automatic drive(input bit r, input bit st, input bit sa, input bit smp,
                       input bit en, input bit md, input int lim);
    rst_n        = r;
    bus.stop_i   = st;
    bus.start_i  = sa;
    bus.sample_i = smp;
    bus.enable_i = en;
    bus.mode_i   = md;
    bus.limit_i  = 17'(lim);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic start_run(input bit md, input int lim);
    drive(1, 0, 1, 0, 1, md, lim);
  endtask
  task automatic strobes(input int n, input bit en);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 1, en, 0, 0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 1, 0, 0);
  endtask

  typedef struct {
    bit r, st, sa, smp, en, md;
    int lim;
    int cnt;
    bit busy, done, wrap;
    int wraps;
  } vec_t;
  vec_t vq[$];

  function automatic vec_t mk(bit r, bit st, bit sa, bit smp, bit en, bit md, int lim,
                              int cnt, bit busy, bit done, bit wrap, int wraps);
    vec_t v;
    v.r = r; v.st = st; v.sa = sa; v.smp = smp; v.en = en; v.md = md; v.lim = lim;
    v.cnt = cnt; v.busy = busy; v.done = done; v.wrap = wrap; v.wraps = wraps;
    return v;
  endfunction

  initial begin
    rst_n = 0;
    bus.enable_i = 0; bus.sample_i = 0; bus.start_i = 0; bus.stop_i = 0;
    bus.mode_i = 0; bus.limit_i = '0;

    // reset held 3 clk with start/sample toggling, then sampling in IDLE
    for (int i = 0; i < 3; i++) vq.push_back(mk(0, 0, i[0], ~i[0], 1, 0, 5, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) vq.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    // one-shot limit 5
    vq.push_back(mk(1, 0, 1, 0, 1, 0, 5, 0, 1, 0, 0, 0));
    for (int k = 1; k <= 5; k++) vq.push_back(mk(1, 0, 0, 1, 1, 0, 0, k % 5, k < 5, k == 5, 0, 0));
    for (int k = 0; k < 3; k++)  vq.push_back(mk(1, 0, 0, 1, 1, 1, 2, 0, 0, 1, 0, 0));
    // continuous limit 3, 10 strobes
    vq.push_back(mk(1, 0, 1, 0, 1, 1, 3, 0, 1, 0, 0, 0));
    for (int k = 1; k <= 10; k++) vq.push_back(mk(1, 0, 0, 1, 1, 0, 7, k % 3, 1, 0, (k % 3) == 0, k / 3));

    foreach (vq[i]) begin
      drive(vq[i].r, vq[i].st, vq[i].sa, vq[i].smp, vq[i].en, vq[i].md, vq[i].lim);
      chk($sformatf("vec%0d_count", i), bus.count_o, vq[i].cnt);
      chk($sformatf("vec%0d_busy",  i), bus.busy_o,  vq[i].busy);
      chk($sformatf("vec%0d_done",  i), bus.done_o,  vq[i].done);
      chk($sformatf("vec%0d_wrap",  i), bus.wrap_o,  vq[i].wrap);
      chk($sformatf("vec%0d_wraps", i), bus.wraps_o, vq[i].wraps);
    end

    // wrap counter saturation on the 2-bit instance
    start_run(1, 3);
    strobes(15, 1);
    chk("sat_wraps2", bus2.wraps_o, 3);
    chk("sat_wraps8", bus.wraps_o, 5);

    // pause with enable low, then finish
    start_run(0, 4);
    strobes(2, 1);
    strobes(5, 0);
    chk("pause_hold", bus.count_o, 2);
    chk("pause_busy", bus.busy_o, 1);
    strobes(2, 1);
    chk("pause_done", bus.done_o, 1);

    // default limit: 125000 on the main build, 200 on the small build
    start_run(0, 0);
    strobes(199, 1);
    chk("dflt_pre_done", bus2.done_o, 0);
    chk("dflt_pre_cnt",  bus2.count_o, 199);
    strobes(1, 1);
    chk("dflt_done",     bus2.done_o, 1);
    chk("dflt_main_cnt", bus.count_o, 200);
    chk("dflt_main_busy", bus.busy_o, 1);

    // stop with the terminal strobe, in both modes
    start_run(0, 4);
    strobes(3, 1);
    drive(1, 1, 0, 1, 1, 0, 0);
    chk("stop_term_done", bus.done_o, 0);
    chk("stop_term_busy", bus.busy_o, 0);
    start_run(1, 4);
    strobes(3, 1);
    drive(1, 1, 0, 1, 1, 0, 0);
    chk("stop_term_wrap", bus.wrap_o, 0);
    chk("stop_term_cnt",  bus.count_o, 0);
    // start with sample, then start with stop
    start_run(0, 4);
    strobes(2, 1);
    drive(1, 0, 1, 1, 1, 0, 4);
    chk("start_smp_cnt", bus.count_o, 0);
    drive(1, 1, 1, 0, 1, 0, 4);
    chk("start_stop_busy", bus.busy_o, 0);

    // restart mid-run with a new limit
    start_run(0, 10);
    strobes(7, 1);
    chk("restart_pre", bus.count_o, 7);
    start_run(0, 2);
    chk("restart_cnt", bus.count_o, 0);
    strobes(2, 1);
    chk("restart_done", bus.done_o, 1);

    // reset mid-run
    start_run(1, 10);
    strobes(3, 1);
    drive(0, 0, 0, 1, 1, 0, 0);
    chk("rst_mid_cnt",  bus.count_o, 0);
    chk("rst_mid_busy", bus.busy_o, 0);
    idle(2);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 200) != 0, ($urandom % 40) == 0, ($urandom % 25) == 0,
            ($urandom % 3) != 0, ($urandom % 6) != 0, $urandom % 2, $urandom % 7);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
